seq_bus_datapath: RTL and testbench



---
 rtl/seq_bus_datapath_pkg.sv | 50 +++++
 rtl/seq_bus_datapath_mul.sv | 44 ++++
 rtl/seq_bus_datapath.sv | 176 +++++++++++++++++
 tb/tb_seq_bus_datapath.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_bus_datapath_pkg.sv
// Shared opcodes, sequencer states and the ALU helper for seq_bus_datapath.
// alu_f works on a 64-bit container; callers zero-extend and truncate, so WIDTH may not exceed 64.
package seq_bus_datapath_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SHL  = 4'd4,
    OP_SHR  = 4'd5,
    OP_ADDI = 4'd6,
    OP_LD   = 4'd7,
    OP_ST   = 4'd8,
    OP_IN   = 4'd9,
    OP_OUT  = 4'd10,
    OP_MUL  = 4'd11,
    OP_MFHI = 4'd12,
    OP_MFLO = 4'd13
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    S_Y,
    S_Z,
    S_WB,
    S_MEM,
    S_MUL,
    S_ERR
  } state_e;

  // Operands arrive zero-extended, so the logical right shift and the
  // wrapping add/sub are exact once the caller truncates to WIDTH.
  function automatic logic [MAX_W-1:0] alu_f(input logic [3:0]       op,
                                             input logic [MAX_W-1:0] a,
                                             input logic [MAX_W-1:0] b,
                                             input logic [5:0]       sh);
    case (op)
      OP_SUB:  alu_f = a - b;
      OP_AND:  alu_f = a & b;
      OP_OR:   alu_f = a | b;
      OP_SHL:  alu_f = a << sh;
      OP_SHR:  alu_f = a >> sh;
      default: alu_f = a + b;
    endcase
  endfunction

endpackage

// File: rtl/seq_bus_datapath_mul.sv
// Iterative unsigned shift-add multiplier (built only with SEQ_BUS_DATAPATH_MUL_EN).
// start_i loads operands; WIDTH steps follow, done_o flags the last step; product_o is final the cycle after.
module seq_bus_datapath_mul #(
  parameter int WIDTH = 32
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      cnt_q;

  always_ff @(posedge Clock) begin
    if (clear) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else if (start_i) begin
      acc_q    <= '0;
      mcand_q  <= (2*WIDTH)'(a_i);
      mplier_q <= b_i;
      cnt_q    <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  assign done_o    = (cnt_q == CW'(1));
  assign product_o = acc_q;

endmodule

// File: rtl/seq_bus_datapath.sv
// Single-bus datapath that sequences one command per handshake: ALU ops retire 3 cycles after accept,
// memory ops wait on mem_ack, MUL (SEQ_BUS_DATAPATH_MUL_EN) takes WIDTH+2; cmd_ready is high only in IDLE.
module seq_bus_datapath
  import seq_bus_datapath_pkg::*;
#(
  parameter int  WIDTH    = 32,
  parameter int  NUM_REGS = 16,
  parameter int  ADDR_W   = 9,
  localparam int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              Clock,
  input  logic              clear,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [REG_AW-1:0] cmd_ra,
  input  logic [REG_AW-1:0] cmd_rb,
  input  logic [REG_AW-1:0] cmd_rc,
  input  logic [WIDTH-1:0]  cmd_imm,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  input  logic [WIDTH-1:0]  in_port,
  output logic [WIDTH-1:0]  out_port,
  input  logic [REG_AW-1:0] dbg_rsel,
  output logic [WIDTH-1:0]  dbg_rdata
);

  localparam int SHW = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [3:0]         op_q;
  logic [REG_AW-1:0]  ra_q, rb_q, rc_q;
  logic [WIDTH-1:0]   imm_q;
  logic [WIDTH-1:0]   regs_q [NUM_REGS];
  logic [WIDTH-1:0]   y_q, z_q, mdr_q, hi_q, lo_q, out_q;
  logic [ADDR_W-1:0]  mar_q;

  logic [WIDTH-1:0]   ra_val, rb_val, rc_val, base, alu_b, alu_w;
  logic [3:0]         alu_op;
  logic               imm_op, legal, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  always_comb begin
    ra_val = regs_q[ra_q];
    rb_val = regs_q[rb_q];
    rc_val = regs_q[rc_q];
    imm_op = (op_q == OP_ADDI) || (op_q == OP_LD) || (op_q == OP_ST);
    // R0 reads as zero only when it is the base of an immediate-form op.
    base   = (imm_op && (rb_q == '0)) ? '0 : rb_val;
    alu_b  = imm_op ? imm_q : rc_val;
    alu_op = imm_op ? OP_ADD : op_q;
    alu_w  = WIDTH'(alu_f(alu_op, MAX_W'(y_q), MAX_W'(alu_b), 6'(rc_val[SHW-1:0])));
  end

`ifdef SEQ_BUS_DATAPATH_MUL_EN
  assign legal = (cmd_op <= OP_MFLO);

  seq_bus_datapath_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .Clock    (Clock),
    .clear    (clear),
    .start_i  ((state_q == S_Y) && (op_q == OP_MUL)),
    .a_i      (rb_val),
    .b_i      (rc_val),
    .done_o   (mul_done),
    .product_o(mul_product)
  );
`else
  assign legal       = (cmd_op <= OP_OUT);
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          if (legal) state_d = S_Y;
          else       state_d = S_ERR;
        end
      end
      S_Y: begin
        if (op_q == OP_MUL) state_d = S_MUL;
        else                state_d = S_Z;
      end
      S_Z: begin
        if ((op_q == OP_LD) || (op_q == OP_ST)) state_d = S_MEM;
        else                                    state_d = S_WB;
      end
      S_MEM:   if (mem_ack)  state_d = S_WB;
      S_MUL:   if (mul_done) state_d = S_WB;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      imm_q   <= '0;
      y_q     <= '0;
      z_q     <= '0;
      mdr_q   <= '0;
      mar_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      out_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            ra_q  <= cmd_ra;
            rb_q  <= cmd_rb;
            rc_q  <= cmd_rc;
            imm_q <= cmd_imm;
          end
        end
        S_Y: y_q <= base;
        S_Z: begin
          case (op_q)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR, OP_ADDI: z_q <= alu_w;
            OP_LD: mar_q <= alu_w[ADDR_W-1:0];
            OP_ST: begin
              mar_q <= alu_w[ADDR_W-1:0];
              mdr_q <= ra_val;
            end
            OP_IN:   z_q   <= in_port;
            OP_OUT:  out_q <= ra_val;
            OP_MFHI: z_q   <= hi_q;
            OP_MFLO: z_q   <= lo_q;
            default: ;
          endcase
        end
        S_MEM: if (mem_ack && (op_q == OP_LD)) mdr_q <= mem_rdata;
        S_WB: begin
          case (op_q)
            OP_LD:         regs_q[ra_q] <= mdr_q;
            OP_ST, OP_OUT: ;
            OP_MUL: begin
`ifdef SEQ_BUS_DATAPATH_MUL_EN
              {hi_q, lo_q} <= mul_product;
`endif
            end
            default:       regs_q[ra_q] <= z_q;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign done      = (state_q == S_WB) || (state_q == S_ERR);
  assign err       = (state_q == S_ERR);
  assign mem_req   = (state_q == S_MEM);
  assign mem_we    = (state_q == S_MEM) && (op_q == OP_ST);
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign out_port  = out_q;
  assign dbg_rdata = regs_q[dbg_rsel];

endmodule

// File: tb/tb_seq_bus_datapath.sv
// Directed bench for seq_bus_datapath; covers the MUL path both with and without SEQ_BUS_DATAPATH_MUL_EN.
module tb_seq_bus_datapath;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4, OP_SHR = 4'd5, OP_ADDI = 4'd6, OP_LD = 4'd7;
  localparam logic [3:0] OP_ST = 4'd8, OP_IN = 4'd9, OP_OUT = 4'd10, OP_MUL = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12, OP_MFLO = 4'd13;

  logic        Clock = 1'b0;
  logic        clear, cmd_valid, cmd_ready, done, err, mem_req, mem_we, mem_ack;
  logic [3:0]  cmd_op, cmd_ra, cmd_rb, cmd_rc, dbg_rsel;
  logic [31:0] cmd_imm, mem_wdata, mem_rdata, in_port, out_port, dbg_rdata;
  logic [8:0]  mem_addr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_regs [16];
  logic [31:0] mem_model [512];
  int          ack_delay = 1;

  int          cyc, rdy_low, req_cyc;
  logic        err_s, stable;
  logic [8:0]  addr_s;
  logic [31:0] wdat_s;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;
    logic [31:0] imm;
    logic [31:0] res;
  } vec_t;

  vec_t alu_tbl [15] = '{
    '{OP_ADDI, 4'd2,  4'd0, 4'd0,  32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{OP_ADDI, 4'd3,  4'd0, 4'd0,  32'h1,         32'h1},
    '{OP_ADDI, 4'd6,  4'd0, 4'd0,  32'd33,        32'd33},
    '{OP_ADDI, 4'd4,  4'd0, 4'd0,  32'h55,        32'h55},
    '{OP_ADD,  4'd4,  4'd2, 4'd3,  32'h0,         32'h0},
    '{OP_SHL,  4'd5,  4'd3, 4'd6,  32'h0,         32'h2},
    '{OP_SUB,  4'd10, 4'd6, 4'd3,  32'h0,         32'h20},
    '{OP_SUB,  4'd11, 4'd3, 4'd6,  32'h0,         32'hFFFF_FFE0},
    '{OP_AND,  4'd12, 4'd6, 4'd11, 32'h0,         32'h20},
    '{OP_OR,   4'd13, 4'd3, 4'd11, 32'h0,         32'hFFFF_FFE1},
    '{OP_SHR,  4'd14, 4'd2, 4'd6,  32'h0,         32'h7FFF_FFFF},
    '{OP_ADDI, 4'd0,  4'd0, 4'd0,  32'h7,         32'h7},
    '{OP_ADDI, 4'd15, 4'd0, 4'd0,  32'h3,         32'h3},
    '{OP_ADD,  4'd9,  4'd0, 4'd3,  32'h0,         32'h8},
    '{OP_ADDI, 4'd15, 4'd1, 4'd0,  32'hFFFF_FFFD, 32'h2}
  };

  seq_bus_datapath dut (
    .Clock    (Clock),
    .clear    (clear),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_ra   (cmd_ra),
    .cmd_rb   (cmd_rb),
    .cmd_rc   (cmd_rc),
    .cmd_imm  (cmd_imm),
    .done     (done),
    .err      (err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .in_port  (in_port),
    .out_port (out_port),
    .dbg_rsel (dbg_rsel),
    .dbg_rdata(dbg_rdata)
  );

  always #20 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Issues one command, plays memory, and returns after the retire edge.
  task automatic run_cmd(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                         input logic [3:0] rc, input logic [31:0] imm,
                         output int n_cyc, output logic e_s, output int n_rdy_low,
                         output int n_req, output logic stab, output logic [8:0] a0,
                         output logic [31:0] w0);
    n_cyc = -1; e_s = 1'b0; n_rdy_low = 0; n_req = 0; stab = 1'b1; a0 = '0; w0 = '0;
    cmd_op = op; cmd_ra = ra; cmd_rb = rb; cmd_rc = rc; cmd_imm = imm; cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    tick();
    cmd_valid = 1'b0;
    cmd_op = ~op; cmd_ra = ~ra; cmd_rb = ~rb; cmd_rc = ~rc; cmd_imm = ~imm;
    for (int c = 1; c <= 200; c++) begin
      if (!cmd_ready) n_rdy_low++;
      if (mem_req) begin
        if (n_req == 0) begin
          a0 = mem_addr;
          w0 = mem_wdata;
        end else if ((mem_addr !== a0) || (mem_wdata !== w0)) begin
          stab = 1'b0;
        end
        n_req++;
        if (ack_delay != 0 && n_req == ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr];
        end
      end
      if (done) begin
        n_cyc = c;
        e_s   = err;
        break;
      end
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
    end
    tick();
    mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    clear = 1'b1;
    tick();
    tick();
    clear = 1'b0;
    for (int r = 0; r < 16; r++) exp_regs[r] = '0;
    checks++;
    if ({cmd_ready, done, err, mem_req, mem_we} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 10000", {cmd_ready, done, err, mem_req, mem_we});
    end
    checks++;
    if (out_port !== 32'h0) begin
      errors++;
      $display("FAIL reset_out_port: got %h expected 0", out_port);
    end
    for (int r = 0; r < 16; r++) begin
      dbg_rsel = 4'(r);
      #1;
      checks++;
      if (dbg_rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_reg R%0d: got %h expected 0", r, dbg_rdata);
      end
    end
  endtask

  task automatic test_addi;
    run_cmd(OP_ADDI, 4'd1, 4'd0, 4'd0, 32'd5, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    exp_regs[1] = 32'd5;
    checks++;
    if (cyc !== 3 || err_s !== 1'b0) begin
      errors++;
      $display("FAIL addi_latency: got cyc=%0d err=%b expected cyc=3 err=0", cyc, err_s);
    end
    checks++;
    if (rdy_low !== 3 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL addi_ready: got low=%0d ready=%b expected low=3 ready=1", rdy_low, cmd_ready);
    end
    dbg_rsel = 4'd1;
    #1;
    checks++;
    if (dbg_rdata !== 32'd5) begin
      errors++;
      $display("FAIL addi_r1: got %h expected 5", dbg_rdata);
    end
  endtask

  task automatic test_alu;
    for (int i = 0; i < 15; i++) begin
      run_cmd(alu_tbl[i].op, alu_tbl[i].ra, alu_tbl[i].rb, alu_tbl[i].rc, alu_tbl[i].imm,
              cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
      exp_regs[alu_tbl[i].ra] = alu_tbl[i].res;
      checks++;
      if (cyc !== 3 || err_s !== 1'b0) begin
        errors++;
        $display("FAIL alu[%0d]_latency: got cyc=%0d err=%b expected cyc=3 err=0", i, cyc, err_s);
      end
      dbg_rsel = alu_tbl[i].ra;
      #1;
      checks++;
      if (dbg_rdata !== alu_tbl[i].res) begin
        errors++;
        $display("FAIL alu[%0d] R%0d: got %h expected %h", i, alu_tbl[i].ra, dbg_rdata, alu_tbl[i].res);
      end
    end
  endtask

  task automatic test_mem;
    ack_delay = 4;
    run_cmd(OP_ST, 4'd1, 4'd0, 4'd0, 32'h10, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    checks++;
    if (cyc !== 7 || req_cyc !== 4 || err_s !== 1'b0) begin
      errors++;
      $display("FAIL st_timing: got cyc=%0d req=%0d err=%b expected cyc=7 req=4 err=0", cyc, req_cyc, err_s);
    end
    checks++;
    if (addr_s !== 9'h010 || wdat_s !== 32'd5 || stable !== 1'b1) begin
      errors++;
      $display("FAIL st_bus: got addr=%h wdata=%h stable=%b expected 010 5 1", addr_s, wdat_s, stable);
    end
    ack_delay = 1;
    run_cmd(OP_LD, 4'd7, 4'd0, 4'd0, 32'h10, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    exp_regs[7] = 32'd5;
    dbg_rsel = 4'd7;
    #1;
    checks++;
    if (cyc !== 4 || dbg_rdata !== 32'd5) begin
      errors++;
      $display("FAIL ld_r7: got cyc=%0d R7=%h expected cyc=4 R7=5", cyc, dbg_rdata);
    end
    ack_delay = 2;
    run_cmd(OP_LD, 4'd8, 4'd1, 4'd0, 32'hF, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    exp_regs[8] = 32'h1234;
    dbg_rsel = 4'd8;
    #1;
    checks++;
    if (addr_s !== 9'h014 || dbg_rdata !== 32'h1234) begin
      errors++;
      $display("FAIL ld_base: got addr=%h R8=%h expected 014 1234", addr_s, dbg_rdata);
    end
    ack_delay = 1;
    run_cmd(OP_LD, 4'd12, 4'd1, 4'd0, 32'h20B, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    exp_regs[12] = 32'd5;
    dbg_rsel = 4'd12;
    #1;
    checks++;
    if (addr_s !== 9'h010 || dbg_rdata !== 32'd5) begin
      errors++;
      $display("FAIL ld_wrap: got addr=%h R12=%h expected 010 5", addr_s, dbg_rdata);
    end
  endtask

  task automatic test_io;
    in_port = 32'hA5A5_0001;
    run_cmd(OP_IN, 4'd14, 4'd0, 4'd0, 32'h0, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    exp_regs[14] = 32'hA5A5_0001;
    dbg_rsel = 4'd14;
    #1;
    checks++;
    if (cyc !== 3 || dbg_rdata !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL in_r14: got cyc=%0d R14=%h expected cyc=3 R14=a5a50001", cyc, dbg_rdata);
    end
    run_cmd(OP_OUT, 4'd13, 4'd0, 4'd0, 32'h0, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    checks++;
    if (cyc !== 3 || out_port !== 32'hFFFF_FFE1) begin
      errors++;
      $display("FAIL out_port: got cyc=%0d out=%h expected cyc=3 out=ffffffe1", cyc, out_port);
    end
  endtask

  task automatic test_illegal;
    for (int k = 14; k < 16; k++) begin
      run_cmd(4'(k), 4'd1, 4'd2, 4'd3, 32'h0, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
      checks++;
      if (cyc !== 1 || err_s !== 1'b1 || cmd_ready !== 1'b1) begin
        errors++;
        $display("FAIL illegal_op%0d: got cyc=%0d err=%b ready=%b expected 1 1 1", k, cyc, err_s, cmd_ready);
      end
    end
    for (int r = 0; r < 16; r++) begin
      dbg_rsel = 4'(r);
      #1;
      checks++;
      if (dbg_rdata !== exp_regs[r]) begin
        errors++;
        $display("FAIL illegal_keep R%0d: got %h expected %h", r, dbg_rdata, exp_regs[r]);
      end
    end
  endtask

  task automatic test_mul;
`ifdef SEQ_BUS_DATAPATH_MUL_EN
    run_cmd(OP_MUL, 4'd9, 4'd2, 4'd15, 32'h0, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    dbg_rsel = 4'd9;
    #1;
    checks++;
    if (cyc !== 34 || err_s !== 1'b0 || dbg_rdata !== 32'h8) begin
      errors++;
      $display("FAIL mul_run: got cyc=%0d err=%b R9=%h expected 34 0 8", cyc, err_s, dbg_rdata);
    end
    run_cmd(OP_MFHI, 4'd8, 4'd0, 4'd0, 32'h0, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    exp_regs[8] = 32'h1;
    dbg_rsel = 4'd8;
    #1;
    checks++;
    if (dbg_rdata !== 32'h1) begin
      errors++;
      $display("FAIL mul_hi: got %h expected 1", dbg_rdata);
    end
    run_cmd(OP_MFLO, 4'd9, 4'd0, 4'd0, 32'h0, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
    exp_regs[9] = 32'hFFFF_FFFE;
    dbg_rsel = 4'd9;
    #1;
    checks++;
    if (dbg_rdata !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL mul_lo: got %h expected fffffffe", dbg_rdata);
    end
`else
    for (int k = 11; k < 14; k++) begin
      run_cmd(4'(k), 4'd9, 4'd2, 4'd15, 32'h0, cyc, err_s, rdy_low, req_cyc, stable, addr_s, wdat_s);
      dbg_rsel = 4'd9;
      #1;
      checks++;
      if (cyc !== 1 || err_s !== 1'b1 || dbg_rdata !== exp_regs[9]) begin
        errors++;
        $display("FAIL mul_off_op%0d: got cyc=%0d err=%b R9=%h expected 1 1 %h", k, cyc, err_s, dbg_rdata, exp_regs[9]);
      end
    end
`endif
  endtask

  task automatic test_clear_mem;
    logic seen;
    seen = 1'b0;
    cmd_op = OP_LD; cmd_ra = 4'd7; cmd_rb = 4'd0; cmd_rc = 4'd0; cmd_imm = 32'h30;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL clr_reach_mem: got mem_req=%b expected 1", mem_req);
    end
    clear = 1'b1;
    tick();
    checks++;
    if (mem_req !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_abort: got req=%b done=%b ready=%b expected 0 0 1", mem_req, done, cmd_ready);
    end
    clear = 1'b0;
    for (int r = 0; r < 16; r++) begin
      dbg_rsel = 4'(r);
      #1;
      checks++;
      if (dbg_rdata !== 32'h0) begin
        errors++;
        $display("FAIL clr_reg R%0d: got %h expected 0", r, dbg_rdata);
      end
    end
    tick();
    checks++;
    if (done !== 1'b0 || out_port !== 32'h0) begin
      errors++;
      $display("FAIL clr_after: got done=%b out=%h expected 0 0", done, out_port);
    end
  endtask

  initial begin
    clear = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rc = '0;
    cmd_imm = '0; mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF; in_port = '0; dbg_rsel = '0;
    for (int a = 0; a < 512; a++) mem_model[a] = 32'h0;
    mem_model[16] = 32'h77;
    mem_model[20] = 32'h1234;
    test_reset();
    test_addi();
    test_alu();
    test_mem();
    test_io();
    test_illegal();
    test_mul();
    test_clear_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
